// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D cache AHB-Lite master arbiter.
package mem_bus_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int LINE_W = 128;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR4  = 3'b011
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_BURST,
    ARB_LAST
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  typedef struct packed {
    logic [27:0] line;
    logic [3:0]  offset;
  } dcache_addr_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        idx);
    return line[WORD_W*idx +: WORD_W];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way I/D arbiter: combinational grant, registered last-grant for round-robin,
// with an optional fixed priority for the dcache.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

  gnt_t last_q;

  always_comb begin
    i_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    if (d_req_i && !i_req_i) begin
      d_gnt_o = 1'b1;
    end else if (i_req_i && !d_req_i) begin
      i_gnt_o = 1'b1;
    end else if (i_req_i && d_req_i) begin
      // On a tie the side that did not win last time goes first.
      if (FIXED_PRIO || last_q == GNT_I) begin
        d_gnt_o = 1'b1;
      end else begin
        i_gnt_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_I;
    end else if (en_i && (i_gnt_o || d_gnt_o)) begin
      last_q <= d_gnt_o ? GNT_D : GNT_I;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one AHB-Lite master between icache SINGLE reads and dcache INCR4 line bursts.
//   state     | meaning
//   ARB_IDLE  | waiting for a request; grant and latch it
//   ARB_ADDR  | beat 0 address phase (NONSEQ)
//   ARB_BURST | dcache beats 1..3 address phases (SEQ), overlapping prior data phase
//   ARB_LAST  | bus idle, waiting for the final data phase, then respond
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ireq_valid_i,
  input  logic [WORD_W-1:0]   ireq_addr_i,
  output logic                ireq_ready_o,
  output logic                irsp_valid_o,
  output logic [WORD_W-1:0]   irsp_data_o,
  output logic                irsp_err_o,
  input  logic                dreq_valid_i,
  input  logic                dreq_write_i,
  input  logic [WORD_W-1:0]   dreq_addr_i,
  input  logic [LINE_W-1:0]   dreq_wdata_i,
  output logic                dreq_ready_o,
  output logic                drsp_valid_o,
  output logic [LINE_W-1:0]   drsp_rdata_o,
  output logic                drsp_err_o,
  output logic [WORD_W-1:0]   haddr_o,
  output htrans_t             htrans_o,
  output logic                hwrite_o,
  output logic [2:0]          hsize_o,
  output logic [2:0]          hburst_o,
  output logic [WORD_W-1:0]   hwdata_o,
  input  logic [WORD_W-1:0]   hrdata_i,
  input  logic                hready_i,
  input  logic                hresp_i
);

  if (LINE_WORDS != 4) begin : g_line_words_check
    $error("mem_bus_arbiter: LINE_WORDS must be 4 (INCR4 line bursts)");
  end

  arb_state_t          state_q;
  logic                is_d_q;
  logic [27:0]         line_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [1:0]          beat_q;
  logic                dp_valid_q;
  logic [1:0]          dp_beat_q;
  logic                err_q;
  logic [LINE_W-1:0]   rdata_q;
  logic [WORD_W-1:0]   haddr_q;
  htrans_t             htrans_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  hburst_t             hburst_q;
  logic [WORD_W-1:0]   hwdata_q;
  logic                irsp_valid_q;
  logic                irsp_err_q;
  logic                drsp_valid_q;
  logic                drsp_err_q;

  logic                grant_en;
  logic                gnt_i;
  logic                gnt_d;
  logic                addr_acc;
  logic                err_first;
  dcache_addr_t        daddr;
  logic                unused_addr_bits;

  assign daddr            = dcache_addr_t'(dreq_addr_i);
  assign unused_addr_bits = ^{ireq_addr_i[1:0], daddr.offset};

  // Hold off a new grant while a response pulse is still on the wire.
  assign grant_en = (state_q == ARB_IDLE) && !irsp_valid_q && !drsp_valid_q;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr_arbiter2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (grant_en),
    .i_req_i(ireq_valid_i),
    .d_req_i(dreq_valid_i),
    .i_gnt_o(gnt_i),
    .d_gnt_o(gnt_d)
  );

  assign ireq_ready_o = grant_en & gnt_i;
  assign dreq_ready_o = grant_en & gnt_d;

  assign addr_acc  = hready_i && (htrans_q == HTRANS_NONSEQ || htrans_q == HTRANS_SEQ);
  assign err_first = dp_valid_q && hresp_i && !hready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      is_d_q       <= 1'b0;
      line_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      dp_valid_q   <= 1'b0;
      dp_beat_q    <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      haddr_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      hburst_q     <= HBURST_SINGLE;
      hwdata_q     <= '0;
      irsp_valid_q <= 1'b0;
      irsp_err_q   <= 1'b0;
      drsp_valid_q <= 1'b0;
      drsp_err_q   <= 1'b0;
    end else begin
      irsp_valid_q <= 1'b0;
      irsp_err_q   <= 1'b0;
      drsp_valid_q <= 1'b0;
      drsp_err_q   <= 1'b0;

      if (dp_valid_q && hready_i) begin
        rdata_q[WORD_W*dp_beat_q +: WORD_W] <= hrdata_i;
      end
      if (dp_valid_q && hresp_i) begin
        err_q <= 1'b1;
      end

      // An accepted address phase opens the data phase of that beat next cycle.
      if (addr_acc) begin
        dp_valid_q <= 1'b1;
        dp_beat_q  <= beat_q;
        hwdata_q   <= line_word(wdata_q, beat_q);
      end else if (hready_i) begin
        dp_valid_q <= 1'b0;
      end

      case (state_q)
        ARB_IDLE: begin
          if (grant_en && (gnt_i || gnt_d)) begin
            is_d_q   <= gnt_d;
            line_q   <= daddr.line;
            wdata_q  <= gnt_d ? dreq_wdata_i : '0;
            beat_q   <= 2'd0;
            err_q    <= 1'b0;
            haddr_q  <= gnt_d ? {daddr.line, 4'h0} : {ireq_addr_i[31:2], 2'b00};
            htrans_q <= HTRANS_NONSEQ;
            hwrite_q <= gnt_d & dreq_write_i;
            hsize_q  <= HSIZE_WORD;
            hburst_q <= gnt_d ? HBURST_INCR4 : HBURST_SINGLE;
            state_q  <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (hready_i) begin
            if (is_d_q) begin
              beat_q   <= 2'd1;
              haddr_q  <= {line_q, 2'd1, 2'b00};
              htrans_q <= HTRANS_SEQ;
              state_q  <= ARB_BURST;
            end else begin
              htrans_q <= HTRANS_IDLE;
              state_q  <= ARB_LAST;
            end
          end
        end
        ARB_BURST: begin
          if (err_first) begin
            htrans_q <= HTRANS_IDLE;
            state_q  <= ARB_LAST;
          end else if (hready_i) begin
            if (beat_q == 2'd3) begin
              htrans_q <= HTRANS_IDLE;
              state_q  <= ARB_LAST;
            end else begin
              beat_q   <= beat_q + 2'd1;
              haddr_q  <= {line_q, beat_q + 2'd1, 2'b00};
              htrans_q <= HTRANS_SEQ;
            end
          end
        end
        ARB_LAST: begin
          if (hready_i) begin
            if (is_d_q) begin
              drsp_valid_q <= 1'b1;
              drsp_err_q   <= err_q | (dp_valid_q & hresp_i);
            end else begin
              irsp_valid_q <= 1'b1;
              irsp_err_q   <= err_q | (dp_valid_q & hresp_i);
            end
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign irsp_valid_o = irsp_valid_q;
  assign irsp_data_o  = rdata_q[WORD_W-1:0];
  assign irsp_err_o   = irsp_err_q;
  assign drsp_valid_o = drsp_valid_q;
  assign drsp_rdata_o = rdata_q;
  assign drsp_err_o   = drsp_err_q;
  assign haddr_o      = haddr_q;
  assign htrans_o     = htrans_q;
  assign hwrite_o     = hwrite_q;
  assign hsize_o      = hsize_q;
  assign hburst_o     = hburst_q;
  assign hwdata_o     = hwdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: bus timing checked per cycle, responses via a scoreboard.
module tb_mem_bus_arbiter;

  typedef struct {
    logic         is_d;
    logic         chk_data;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         ireq_valid;
  logic [31:0]  ireq_addr;
  logic         ireq_ready;
  logic         irsp_valid;
  logic [31:0]  irsp_data;
  logic         irsp_err;
  logic         dreq_valid;
  logic         dreq_write;
  logic [31:0]  dreq_addr;
  logic [127:0] dreq_wdata;
  logic         dreq_ready;
  logic         drsp_valid;
  logic [127:0] drsp_rdata;
  logic         drsp_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [31:0]  hwdata;
  logic [31:0]  hrdata;
  logic         hready;
  logic         hresp;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [31:0] rd2    [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] t3_off [9] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC, 32'h0, 32'h0};
  logic [1:0]  t3_tr  [9] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [31:0] t3_wd  [9] = '{32'h0, 32'h0, 32'hAAAA0001, 32'hBBBB0002, 32'hBBBB0002,
                              32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 32'h0};

  mem_bus_arbiter #(
    .FIXED_PRIO(1'b0),
    .LINE_WORDS(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ireq_valid_i(ireq_valid),
    .ireq_addr_i (ireq_addr),
    .ireq_ready_o(ireq_ready),
    .irsp_valid_o(irsp_valid),
    .irsp_data_o (irsp_data),
    .irsp_err_o  (irsp_err),
    .dreq_valid_i(dreq_valid),
    .dreq_write_i(dreq_write),
    .dreq_addr_i (dreq_addr),
    .dreq_wdata_i(dreq_wdata),
    .dreq_ready_o(dreq_ready),
    .drsp_valid_o(drsp_valid),
    .drsp_rdata_o(drsp_rdata),
    .drsp_err_o  (drsp_err),
    .haddr_o     (haddr),
    .htrans_o    (htrans),
    .hwrite_o    (hwrite),
    .hsize_o     (hsize),
    .hburst_o    (hburst),
    .hwdata_o    (hwdata),
    .hrdata_i    (hrdata),
    .hready_i    (hready),
    .hresp_i     (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] ex);
    vectors++;
    assert (obs === ex) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, ex);
    end
  endtask

  task automatic push(input logic is_d, input logic cd, input logic [127:0] d, input logic e);
    exp_t x;
    x.is_d     = is_d;
    x.chk_data = cd;
    x.data     = d;
    x.err      = e;
    sb.push_back(x);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rdy, input logic rsp, input logic [31:0] rd);
    hready = rdy;
    hresp  = rsp;
    hrdata = rd;
    @(negedge clk);
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (irsp_valid || drsp_valid) begin
      chk("rsp_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_side", 128'({irsp_valid, drsp_valid}), mon_e.is_d ? 128'(2'b01) : 128'(2'b10));
        if (mon_e.is_d) begin
          chk("drsp_err", 128'(drsp_err), 128'(mon_e.err));
          if (mon_e.chk_data) chk("drsp_rdata", drsp_rdata, mon_e.data);
        end else begin
          chk("irsp_err", 128'(irsp_err), 128'(mon_e.err));
          if (mon_e.chk_data) chk("irsp_data", 128'(irsp_data), mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish by 100000ns, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_d;
    logic got;
    int   acc;
    logic [31:0] pat;

    rst_n      = 1'b0;
    ireq_valid = 1'b0;
    ireq_addr  = '0;
    dreq_valid = 1'b0;
    dreq_write = 1'b0;
    dreq_addr  = '0;
    dreq_wdata = '0;
    hrdata     = '0;
    hready     = 1'b1;
    hresp      = 1'b0;

    #3;
    chk("rst_htrans", 128'(htrans), 128'(0));
    chk("rst_haddr", 128'(haddr), 128'(0));
    chk("rst_hwrite", 128'(hwrite), 128'(0));
    chk("rst_hsize", 128'(hsize), 128'(0));
    chk("rst_hburst", 128'(hburst), 128'(0));
    chk("rst_hwdata", 128'(hwdata), 128'(0));
    chk("rst_rsp_valid", 128'({irsp_valid, drsp_valid}), 128'(0));
    chk("rst_rsp_err", 128'({irsp_err, drsp_err}), 128'(0));
    chk("rst_drsp_rdata", drsp_rdata, 128'(0));
    chk("rst_ready", 128'({ireq_ready, dreq_ready}), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    adv();

    // 1: icache single read, no waits
    ireq_valid = 1'b1;
    ireq_addr  = 32'h0000_1004;
    bus(1'b1, 1'b0, 32'h0);
    chk("t1_ready", 128'(ireq_ready), 128'(1));
    push(1'b0, 1'b1, 128'hDEADBEEF, 1'b0);
    adv();
    ireq_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    chk("t1_htrans_nonseq", 128'(htrans), 128'(2));
    chk("t1_haddr", 128'(haddr), 128'(32'h0000_1004));
    chk("t1_hburst", 128'(hburst), 128'(0));
    chk("t1_hsize", 128'(hsize), 128'(3'b010));
    chk("t1_hwrite", 128'(hwrite), 128'(0));
    adv();
    bus(1'b1, 1'b0, 32'hDEADBEEF);
    chk("t1_htrans_idle", 128'(htrans), 128'(0));
    chk("t1_no_early_rsp", 128'(irsp_valid), 128'(0));
    adv();
    bus(1'b1, 1'b0, 32'h0);
    chk("t1_rsp_at3", 128'(irsp_valid), 128'(1));
    adv();
    bus(1'b1, 1'b0, 32'h0);
    chk("t1_rsp_pulse", 128'(irsp_valid), 128'(0));
    adv();

    // 2: dcache line fill, no waits
    dreq_valid = 1'b1;
    dreq_write = 1'b0;
    dreq_addr  = 32'h2000_0010;
    bus(1'b1, 1'b0, 32'h0);
    chk("t2_ready", 128'({dreq_ready, ireq_ready}), 128'(2'b10));
    push(1'b1, 1'b1, {rd2[3], rd2[2], rd2[1], rd2[0]}, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      adv();
      dreq_valid = 1'b0;
      bus(1'b1, 1'b0, (c >= 2 && c <= 5) ? rd2[c-2] : 32'h0);
      if (c <= 4) begin
        chk("t2_htrans", 128'(htrans), (c == 1) ? 128'(2) : 128'(3));
        chk("t2_haddr", 128'(haddr), 128'(32'h2000_0010 + 32'(4 * (c - 1))));
        chk("t2_hburst", 128'(hburst), 128'(3));
      end else if (c == 5) begin
        chk("t2_htrans_idle", 128'(htrans), 128'(0));
      end
      chk("t2_drsp_valid", 128'(drsp_valid), 128'(c == 6));
    end
    adv();

    // 3: dcache writeback with two wait states on beat 1 data phase
    dreq_valid = 1'b1;
    dreq_write = 1'b1;
    dreq_addr  = 32'h3000_004C;
    dreq_wdata = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    bus(1'b1, 1'b0, 32'h0);
    chk("t3_ready", 128'(dreq_ready), 128'(1));
    push(1'b1, 1'b0, 128'h0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      adv();
      dreq_valid = 1'b0;
      bus(!(c == 3 || c == 4), 1'b0, 32'h0);
      if (c <= 7) begin
        chk("t3_htrans", 128'(htrans), 128'(t3_tr[c]));
        chk("t3_hwrite", 128'(hwrite), 128'(1));
      end
      if (c <= 6) chk("t3_haddr", 128'(haddr), 128'(32'h3000_0040 + t3_off[c]));
      if (c >= 2 && c <= 7) chk("t3_hwdata", 128'(hwdata), 128'(t3_wd[c]));
      chk("t3_drsp_valid", 128'(drsp_valid), 128'(c == 8));
    end
    dreq_write = 1'b0;
    adv();

    // 4: both requesting, round-robin from reset
    rst_n = 1'b0;
    @(negedge clk);
    adv();
    rst_n = 1'b1;
    adv();
    for (int r = 0; r < 6; r++) begin
      exp_d      = (r % 2 == 0);
      pat        = 32'hA500_0000 | 32'(r);
      ireq_valid = 1'b1;
      ireq_addr  = 32'h0000_0100 + 32'(4 * r);
      dreq_valid = 1'b1;
      dreq_addr  = 32'h4000_0000 + 32'(16 * r);
      bus(1'b1, 1'b0, pat);
      chk("t4_grant", 128'({dreq_ready, ireq_ready}), exp_d ? 128'(2'b10) : 128'(2'b01));
      if (exp_d) push(1'b1, 1'b1, {pat, pat, pat, pat}, 1'b0);
      else       push(1'b0, 1'b1, 128'(pat), 1'b0);
      got = 1'b0;
      for (int n = 1; n <= 12 && !got; n++) begin
        adv();
        if (exp_d) dreq_valid = 1'b0;
        else       ireq_valid = 1'b0;
        bus(1'b1, 1'b0, pat);
        chk("t4_busy_ready", 128'({dreq_ready, ireq_ready}), 128'(0));
        if (exp_d ? drsp_valid : irsp_valid) begin
          got = 1'b1;
          chk("t4_latency", 128'(n), exp_d ? 128'(6) : 128'(3));
        end
      end
      chk("t4_rsp_seen", 128'(got), 128'(1));
      adv();
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    adv();

    // 5: dcache fill with ERROR on beat 2
    dreq_valid = 1'b1;
    dreq_addr  = 32'h5000_0000;
    bus(1'b1, 1'b0, 32'h0);
    chk("t5_ready", 128'(dreq_ready), 128'(1));
    push(1'b1, 1'b0, 128'h0, 1'b1);
    acc = 0;
    for (int c = 1; c <= 7; c++) begin
      adv();
      dreq_valid = 1'b0;
      bus(c != 4, (c == 4 || c == 5), 32'h100 + 32'(c));
      if (htrans != 2'd0 && hready) acc++;
      if (c == 5) chk("t5_htrans_idle", 128'(htrans), 128'(0));
      chk("t5_drsp_valid", 128'(drsp_valid), 128'(c == 6));
    end
    chk("t5_beats_issued", 128'(acc), 128'(3));
    adv();

    // 6: reset during beat 1 of a burst, then a fresh icache read
    dreq_valid = 1'b1;
    dreq_addr  = 32'h6000_0000;
    bus(1'b1, 1'b0, 32'h0);
    chk("t6_ready", 128'(dreq_ready), 128'(1));
    adv();
    dreq_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    adv();
    chk("t6_pre_rst_htrans", 128'(htrans), 128'(3));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_htrans", 128'(htrans), 128'(0));
    chk("t6_rst_haddr", 128'(haddr), 128'(0));
    chk("t6_rst_rsp", 128'({irsp_valid, drsp_valid}), 128'(0));
    @(negedge clk);
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus(1'b1, 1'b0, 32'h0);
      chk("t6_no_resume", 128'({htrans, drsp_valid}), 128'(0));
      adv();
    end
    ireq_valid = 1'b1;
    ireq_addr  = 32'h7000_000A;
    bus(1'b1, 1'b0, 32'h0);
    chk("t6_i_ready", 128'(ireq_ready), 128'(1));
    push(1'b0, 1'b1, 128'hCAFEF00D, 1'b0);
    adv();
    ireq_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    chk("t6_i_nonseq", 128'(htrans), 128'(2));
    chk("t6_i_haddr", 128'(haddr), 128'(32'h7000_0008));
    adv();
    bus(1'b1, 1'b0, 32'hCAFEF00D);
    adv();
    bus(1'b1, 1'b0, 32'h0);
    chk("t6_i_rsp_at3", 128'(irsp_valid), 128'(1));
    adv();
    bus(1'b1, 1'b0, 32'h0);

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
